wbu: RTL and testbench

- Write-back stage of the ysyxsoc 5-stage pipeline; last stop for every instruction leaving the MEM stage.
- Holds the single MEM/WB entry and aligns and sign-extends load data.
- Drives the register-file write port and the WB forwarding bus read by the decode stage, and retires instructions to the commit/trace port.
- Counts retired instructions and halts the pipeline when EBREAK retires.

---
 rtl/wbu_if.sv | 50 +++++
 rtl/wbu.sv | 116 +++++++++++
 tb/tb_wbu.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_if.sv
// MEM->WB handshake, register-file write port, forwarding bus and commit/trace port of the write-back stage.
// slave is the WBU's own view; master is the surrounding pipeline's view.
interface wbu_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_inst;
  logic [4:0]       in_rd;
  logic             in_reg_wen;
  logic             in_mem_ren;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic [XLEN-1:0]  in_result;
  logic [XLEN-1:0]  in_load_word;
  logic             in_is_ebreak;

  logic             rf_wen;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;

  logic             wb_valid;
  logic             wb_reg_wen;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_result;

  logic             commit_valid;
  logic             commit_ready;
  logic [XLEN-1:0]  commit_pc;
  logic [31:0]      commit_inst;

  logic [CNT_W-1:0] instret;
  logic             halted;

  modport slave (
    input  in_valid, in_pc, in_inst, in_rd, in_reg_wen, in_mem_ren, in_funct3,
           in_addr_lo, in_result, in_load_word, in_is_ebreak, commit_ready,
    output in_ready, rf_wen, rf_waddr, rf_wdata, wb_valid, wb_reg_wen, wb_rd,
           wb_result, commit_valid, commit_pc, commit_inst, instret, halted
  );

  modport master (
    output in_valid, in_pc, in_inst, in_rd, in_reg_wen, in_mem_ren, in_funct3,
           in_addr_lo, in_result, in_load_word, in_is_ebreak, commit_ready,
    input  in_ready, rf_wen, rf_waddr, rf_wdata, wb_valid, wb_reg_wen, wb_rd,
           wb_result, commit_valid, commit_pc, commit_inst, instret, halted
  );
endinterface

// File: rtl/wbu.sv
// Write-back stage: one-entry MEM/WB register, load align/extend at capture, retire to RF/commit port.
// Result visible one cycle after accept; entry held while commit_ready=0; EBREAK retirement halts until reset.
module wbu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic  clk,
  input  logic  rst,
  wbu_if.slave  bus
);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q;
  logic             halted_q;
  logic [CNT_W-1:0] instret_q;

  logic             vld_q;
  logic [XLEN-1:0]  pc_q;
  logic [31:0]      inst_q;
  logic [4:0]       rd_q;
  logic             wen_q;
  logic             ebreak_q;
  logic [XLEN-1:0]  res_q;

  logic [XLEN-1:0]  res_d;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic             retire_fire;
  logic             accept;
  logic             in_ready_w;

  always_comb begin
    byte_v = 8'(bus.in_load_word >> {bus.in_addr_lo, 3'b000});
    half_v = 16'(bus.in_load_word >> {bus.in_addr_lo[1], 4'b0000});
    res_d  = bus.in_result;
    if (bus.in_mem_ren) begin
      case (bus.in_funct3)
        3'b000:  res_d = {{(XLEN-8){byte_v[7]}}, byte_v};
        3'b001:  res_d = {{(XLEN-16){half_v[15]}}, half_v};
        3'b100:  res_d = {{(XLEN-8){1'b0}}, byte_v};
        3'b101:  res_d = {{(XLEN-16){1'b0}}, half_v};
        default: res_d = bus.in_load_word;
      endcase
    end
  end

  assign retire_fire = vld_q && bus.commit_ready;
  // A retiring EBREAK must not let the next instruction slip in behind it.
  assign in_ready_w  = (state_q == RUN) && (!vld_q || retire_fire) && !(retire_fire && ebreak_q);
  assign accept      = bus.in_valid && in_ready_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      halted_q  <= 1'b0;
      instret_q <= '0;
      vld_q     <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      ebreak_q  <= 1'b0;
      res_q     <= '0;
    end else begin
      if (retire_fire) begin
        instret_q <= instret_q + CNT_W'(1);
      end

      case (state_q)
        RUN: begin
          if (retire_fire && ebreak_q) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase

      if (accept) begin
        vld_q    <= 1'b1;
        pc_q     <= bus.in_pc;
        inst_q   <= bus.in_inst;
        rd_q     <= bus.in_rd;
        wen_q    <= bus.in_reg_wen;
        ebreak_q <= bus.in_is_ebreak;
        res_q    <= res_d;
      end else if (retire_fire) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready_w;
  assign bus.rf_wen       = retire_fire && wen_q && (rd_q != 5'd0);
  assign bus.rf_waddr     = rd_q;
  assign bus.rf_wdata     = res_q;

  assign bus.wb_valid     = vld_q;
  assign bus.wb_reg_wen   = vld_q && wen_q && (rd_q != 5'd0);
  assign bus.wb_rd        = rd_q;
  assign bus.wb_result    = res_q;

  assign bus.commit_valid = vld_q;
  assign bus.commit_pc    = pc_q;
  assign bus.commit_inst  = inst_q;

  assign bus.instret      = instret_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_wbu.sv
// Directed plus random stimulus for wbu, checked against a transaction-level model (pending-retirement queue).
module tb_wbu;

  logic clk;
  logic rst;

  wbu_if #(.XLEN(32), .CNT_W(64)) bus ();

  wbu #(.XLEN(32), .CNT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        eb;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_instret;
  logic        m_halted;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load result derived arithmetically from the byte/half selection rules.
  function automatic logic [31:0] ref_res(input logic ren, input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] res, input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word / (32'd1 << (8 * a))) % 32'd256;
    h = (word / (32'd1 << (16 * (a / 2)))) % 32'd65536;
    if (!ren) return res;
    case (f3)
      3'd0:    return (b < 32'd128)   ? b : b - 32'd256;
      3'd1:    return (h < 32'd32768) ? h : h - 32'd65536;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  task automatic drv(input logic v, input logic [4:0] rd, input logic wen, input logic ren,
                     input logic [2:0] f3, input logic [1:0] a, input logic [31:0] res,
                     input logic [31:0] word, input logic eb);
    bus.in_valid     = v;
    bus.in_pc        = $urandom;
    bus.in_inst      = eb ? 32'h0010_0073 : $urandom;
    bus.in_rd        = rd;
    bus.in_reg_wen   = wen;
    bus.in_mem_ren   = ren;
    bus.in_funct3    = f3;
    bus.in_addr_lo   = a;
    bus.in_result    = res;
    bus.in_load_word = word;
    bus.in_is_ebreak = eb;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic drv_rand(input logic v);
    drv(v, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 3'($urandom),
        2'($urandom), $urandom, $urandom, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    m_instret = '0;
    m_halted  = 1'b0;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step(input logic cr);
    logic have, fire, exp_rdy;
    ent_t e;
    ent_t n;
    bus.commit_ready = cr;
    #1;
    have = (q.size() != 0);
    e    = have ? q[0] : '{default: '0};
    fire = have && cr;
    exp_rdy = !m_halted && (!have || (fire && !e.eb));
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("commit_valid", bus.commit_valid, have);
    chk("wb_valid", bus.wb_valid, have);
    chk("rf_wen", bus.rf_wen, fire && e.wen && (e.rd != 0));
    chk("instret", bus.instret, m_instret);
    chk("halted", bus.halted, m_halted);
    if (have) begin
      chk("commit_pc", bus.commit_pc, e.pc);
      chk("commit_inst", bus.commit_inst, e.inst);
      chk("wb_rd", bus.wb_rd, e.rd);
      chk("wb_result", bus.wb_result, e.res);
      chk("wb_reg_wen", bus.wb_reg_wen, e.wen && (e.rd != 0));
    end
    if (fire && e.wen && (e.rd != 0)) begin
      chk("rf_waddr", bus.rf_waddr, e.rd);
      chk("rf_wdata", bus.rf_wdata, e.res);
    end
    if (fire) begin
      void'(q.pop_front());
      m_instret = m_instret + 64'd1;
      if (e.eb) m_halted = 1'b1;
    end
    if (bus.in_valid && exp_rdy) begin
      n.pc   = bus.in_pc;
      n.inst = bus.in_inst;
      n.rd   = bus.in_rd;
      n.wen  = bus.in_reg_wen;
      n.eb   = bus.in_is_ebreak;
      n.res  = ref_res(bus.in_mem_ren, bus.in_funct3, bus.in_addr_lo, bus.in_result, bus.in_load_word);
      q.push_back(n);
    end
    @(negedge clk);
  endtask

  logic [2:0]  ld_f3  [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0]  ld_a   [6] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3};
  logic [31:0] ld_exp [6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF,
                              32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
  logic [63:0] base;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.commit_ready = 1'b0;
    idle();
    model_reset();
    #12;
    chk("rst_rf_wen", bus.rf_wen, 1'b0);
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_commit_valid", bus.commit_valid, 1'b0);
    chk("rst_instret", bus.instret, 64'd0);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
    chk("rst_commit_pc", bus.commit_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ADD to x5.
    drv(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234, 32'd0, 1'b0);
    step(1'b1);
    idle();
    bus.commit_ready = 1'b1;
    #1;
    chk("add_rf_wen", bus.rf_wen, 1'b1);
    chk("add_rf_waddr", bus.rf_waddr, 5'd5);
    chk("add_rf_wdata", bus.rf_wdata, 32'h1234);
    chk("add_wb_valid", bus.wb_valid, 1'b1);
    @(negedge clk);
    q.delete();
    m_instret = 64'd1;
    chk("add_instret", bus.instret, 64'd1);

    // Load alignment/extension table.
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 5'd10, 1'b1, 1'b1, ld_f3[i], ld_a[i], 32'hDEAD_BEEF, 32'h80FF_7F01, 1'b0);
      step(1'b1);
      idle();
      bus.commit_ready = 1'b1;
      #1;
      chk("load_result", bus.wb_result, ld_exp[i]);
      step(1'b1);
    end

    // Back-to-back stream of 8.
    base = m_instret;
    for (int i = 0; i < 8; i++) begin
      drv_rand(1'b1);
      step(1'b1);
    end
    idle();
    step(1'b1);
    chk("b2b_instret", bus.instret, base + 64'd8);

    // Three-cycle stall with rd=7 held, another instruction waiting.
    drv(1'b1, 5'd7, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0777, 32'd0, 1'b0);
    step(1'b1);
    drv(1'b1, 5'd9, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0999, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.commit_ready = 1'b0;
      #1;
      chk("stall_wb_rd", bus.wb_rd, 5'd7);
      chk("stall_rf_wen", bus.rf_wen, 1'b0);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      step(1'b0);
    end
    step(1'b1);
    idle();
    step(1'b1);
    step(1'b1);

    // rd=0 with reg_wen=1.
    drv(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h5555_5555, 32'd0, 1'b0);
    step(1'b1);
    idle();
    bus.commit_ready = 1'b1;
    #1;
    chk("rd0_rf_wen", bus.rf_wen, 1'b0);
    chk("rd0_wb_reg_wen", bus.wb_reg_wen, 1'b0);
    step(1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      drv_rand(1'($urandom));
      step(1'($urandom));
    end
    idle();
    step(1'b1);

    // Reset while an entry is stalled.
    drv(1'b1, 5'd3, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0333, 32'd0, 1'b0);
    step(1'b1);
    idle();
    step(1'b0);
    bus.commit_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_commit_valid", bus.commit_valid, 1'b0);
    chk("midrst_rf_wen", bus.rf_wen, 1'b0);
    chk("midrst_wb_valid", bus.wb_valid, 1'b0);
    chk("midrst_instret", bus.instret, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // EBREAK retiring with a follower offered.
    drv(1'b1, 5'd4, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0044, 32'd0, 1'b0);
    step(1'b1);
    drv(1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b1);
    step(1'b1);
    drv(1'b1, 5'd6, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0666, 32'd0, 1'b0);
    step(1'b1);
    for (int i = 0; i < 5; i++) begin
      drv_rand(1'b1);
      step(1'b1);
    end
    chk("halt_halted", bus.halted, 1'b1);
    chk("halt_instret", bus.instret, 64'd2);
    chk("halt_commit_valid", bus.commit_valid, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("halt_rst_halted", bus.halted, 1'b0);
    chk("halt_rst_instret", bus.instret, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    step(1'b1);
    drv(1'b1, 5'd8, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0888, 32'd0, 1'b0);
    step(1'b1);
    idle();
    step(1'b1);
    step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
